// File: rtl/vmmul_sched.sv
// Round-robin command scheduler sharing one vmmul engine among NUM_REQ requesters.
// Optional engine watchdog: define VMMUL_SCHED_TIMEOUT_EN.
module vmmul_sched #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_a_addr,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_b_addr,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_r_addr,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic                        rsp_err,
    output logic                        eng_enable,
    output logic                        eng_start,
    output logic [ADDR_W-1:0]           eng_a_addr,
    output logic [ADDR_W-1:0]           eng_b_addr,
    output logic [ADDR_W-1:0]           eng_r_addr,
    input  logic                        eng_done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] q_count
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = IDX_W + 3 * ADDR_W;

    if (NUM_REQ < 2 || NUM_REQ > 8 || FIFO_DEPTH < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("vmmul_sched: unsupported parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    id_q, id_d;
    logic [ADDR_W-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
    logic                first_q, first_d;
    logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];

    logic                full, push, pop;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W:0]      cand;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    head_id;
    logic [ADDR_W-1:0]   head_a, head_b, head_r;

`ifdef VMMUL_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]     wcnt_q, wcnt_d;
    logic                err_q, err_d;
`endif

    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign {head_id, head_a, head_b, head_r} = fifo_mem[rd_ptr_q];

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        push      = 1'b0;
        grant_idx = '0;
        grant     = '0;
        cand      = '0;
        if (!full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
                if (!push && req_valid[cand[IDX_W-1:0]]) begin
                    push      = 1'b1;
                    grant_idx = cand[IDX_W-1:0];
                end
            end
        end
        if (push) grant = NUM_REQ'(1) << grant_idx;
    end

    assign req_ready = grant;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Queue storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {grant_idx,
                                   req_a_addr[grant_idx*ADDR_W +: ADDR_W],
                                   req_b_addr[grant_idx*ADDR_W +: ADDR_W],
                                   req_r_addr[grant_idx*ADDR_W +: ADDR_W]};
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        first_d    = first_q;
        eng_start  = 1'b0;
        eng_enable = 1'b0;
`ifdef VMMUL_SCHED_TIMEOUT_EN
        wcnt_d     = wcnt_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    id_d    = head_id;
                    a_d     = head_a;
                    b_d     = head_b;
                    r_d     = head_r;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start  = 1'b1;
                eng_enable = 1'b1;
                first_d    = 1'b1;
`ifdef VMMUL_SCHED_TIMEOUT_EN
                wcnt_d     = '0;
                err_d      = 1'b0;
`endif
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // First WAIT cycle ignores done so a stale level cannot complete us.
                eng_enable = 1'b1;
                first_d    = 1'b0;
`ifdef VMMUL_SCHED_TIMEOUT_EN
                wcnt_d     = wcnt_q + TO_W'(1);
`endif
                if (!first_q && eng_done) begin
                    state_d = S_RESP;
`ifdef VMMUL_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (wcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
`endif
                end
            end
            S_RESP:  state_d = S_DRAIN;
            S_DRAIN: if (!eng_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            first_q  <= 1'b0;
`ifdef VMMUL_SCHED_TIMEOUT_EN
            wcnt_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            first_q  <= first_d;
`ifdef VMMUL_SCHED_TIMEOUT_EN
            wcnt_q   <= wcnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign rsp_valid  = (state_q == S_RESP) ? (NUM_REQ'(1) << id_q) : '0;
`ifdef VMMUL_SCHED_TIMEOUT_EN
    assign rsp_err    = (state_q == S_RESP) && err_q;
`else
    assign rsp_err    = 1'b0;
`endif
    assign eng_a_addr = a_q;
    assign eng_b_addr = b_q;
    assign eng_r_addr = r_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign q_count    = count_q;

endmodule

// File: tb/tb_vmmul_sched.sv
// Directed bench for vmmul_sched: reset, single command, round robin, full queue,
// stale done, optional watchdog and reset during WAIT.
module tb_vmmul_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_a_addr, req_b_addr, req_r_addr;
    logic [NR-1:0]     rsp_valid;
    logic              rsp_err;
    logic              eng_enable, eng_start;
    logic [AW-1:0]     eng_a_addr, eng_b_addr, eng_r_addr;
    logic              eng_done;
    logic              busy;
    logic [2:0]        q_count;

    int vecs = 0;
    int errs = 0;

    vmmul_sched #(
        .NUM_REQ(NR), .FIFO_DEPTH(4), .ADDR_W(AW), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a_addr(req_a_addr), .req_b_addr(req_b_addr), .req_r_addr(req_r_addr),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .eng_enable(eng_enable), .eng_start(eng_start),
        .eng_a_addr(eng_a_addr), .eng_b_addr(eng_b_addr), .eng_r_addr(eng_r_addr),
        .eng_done(eng_done), .busy(busy), .q_count(q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] exp_a(int i); return 32'h1000 + 32'(16 * i); endfunction
    function automatic logic [AW-1:0] exp_b(int i); return 32'h2000 + 32'(16 * i); endfunction
    function automatic logic [AW-1:0] exp_r(int i); return 32'h3000 + 32'(16 * i); endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load_addrs();
        for (int i = 0; i < NR; i++) begin
            req_a_addr[i*AW +: AW] = exp_a(i);
            req_b_addr[i*AW +: AW] = exp_b(i);
            req_r_addr[i*AW +: AW] = exp_r(i);
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        eng_done  = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; eng_done = 1'b0; load_addrs();
        #1;
        vecs++; if ({eng_start, eng_enable, rsp_err, busy} !== 4'b0) begin errs++; $display("FAIL reset_ctrl: got %b expected 0000", {eng_start, eng_enable, rsp_err, busy}); end
        vecs++; if ({rsp_valid, req_ready, q_count} !== 11'b0) begin errs++; $display("FAIL reset_vec: got %h expected 0", {rsp_valid, req_ready, q_count}); end
        vecs++; if ({eng_a_addr, eng_b_addr, eng_r_addr} !== 96'b0) begin errs++; $display("FAIL reset_addr: got %h expected 0", {eng_a_addr, eng_b_addr, eng_r_addr}); end
    endtask

    task automatic test_single();
        do_reset();
        req_a_addr[2*AW +: AW] = 32'h100;
        req_b_addr[2*AW +: AW] = 32'h200;
        req_r_addr[2*AW +: AW] = 32'h300;
        req_valid = 4'b0100;
        #1;
        vecs++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        step();
        req_valid = '0;
        vecs++; if (q_count !== 3'd1) begin errs++; $display("FAIL single_qcount: got %0d expected 1", q_count); end
        vecs++; if (eng_start !== 1'b0) begin errs++; $display("FAIL single_early_start: got %b expected 0", eng_start); end
        step();
        vecs++; if ({eng_start, eng_enable} !== 2'b11) begin errs++; $display("FAIL single_start: got %b expected 11", {eng_start, eng_enable}); end
        vecs++; if ({eng_a_addr, eng_b_addr, eng_r_addr} !== {32'h100, 32'h200, 32'h300}) begin errs++; $display("FAIL single_addr: got %h expected 100/200/300", {eng_a_addr, eng_b_addr, eng_r_addr}); end
        step();
        vecs++; if ({eng_start, eng_enable} !== 2'b01) begin errs++; $display("FAIL single_wait: got %b expected 01", {eng_start, eng_enable}); end
        repeat (9) step();
        eng_done = 1'b1;
        step();
        vecs++; if ({rsp_valid, rsp_err} !== 5'b0100_0) begin errs++; $display("FAIL single_rsp: got %b expected 01000", {rsp_valid, rsp_err}); end
        vecs++; if (eng_a_addr !== 32'h100) begin errs++; $display("FAIL single_rsp_addr: got %h expected 100", eng_a_addr); end
        step();
        vecs++; if ({rsp_valid, busy, eng_enable} !== 6'b0000_1_0) begin errs++; $display("FAIL single_drain: got %b expected 000010", {rsp_valid, busy, eng_enable}); end
        step();
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL single_drain_hold: got %b expected 1", busy); end
        eng_done = 1'b0;
        step();
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_g [5];
        int order [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        order = '{0, 1, 2, 3, 0};
        do_reset();
        load_addrs();
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1;
            vecs++; if (req_ready !== exp_g[c]) begin errs++; $display("FAIL rr_grant%0d: got %b expected %b", c, req_ready, exp_g[c]); end
            step();
        end
        #1;
        vecs++; if ({req_ready, q_count} !== {4'b0000, 3'd4}) begin errs++; $display("FAIL rr_full: got %b expected 0000100", {req_ready, q_count}); end
        req_valid = '0;
        for (int n = 0; n < 5; n++) begin
            for (int t = 0; t < 40 && eng_enable !== 1'b1; t++) step();
            vecs++; if (eng_enable !== 1'b1) begin errs++; $display("FAIL rr_issue%0d: got %b expected 1", n, eng_enable); end
            vecs++; if ({eng_a_addr, eng_r_addr} !== {exp_a(order[n]), exp_r(order[n])}) begin errs++; $display("FAIL rr_addr%0d: got %h expected %h", n, {eng_a_addr, eng_r_addr}, {exp_a(order[n]), exp_r(order[n])}); end
            eng_done = 1'b1;
            for (int t = 0; t < 40 && rsp_valid === '0; t++) step();
            vecs++; if ({rsp_valid, rsp_err} !== {4'(1 << order[n]), 1'b0}) begin errs++; $display("FAIL rr_rsp%0d: got %b expected %b", n, {rsp_valid, rsp_err}, {4'(1 << order[n]), 1'b0}); end
            eng_done = 1'b0;
            step();
        end
    endtask

    task automatic test_full_fifo();
        int xfers;
        logic [NR-1:0] last;
        do_reset();
        load_addrs();
        req_valid = 4'hF;
        repeat (5) step();
        for (int c = 0; c < 5; c++) begin
            #1;
            vecs++; if ({req_ready, q_count} !== {4'b0000, 3'd4}) begin errs++; $display("FAIL full_stall%0d: got %b expected 0000100", c, {req_ready, q_count}); end
            step();
        end
        eng_done = 1'b1;
        for (int t = 0; t < 40 && rsp_valid === '0; t++) step();
        vecs++; if (rsp_valid !== 4'b0001) begin errs++; $display("FAIL full_rsp: got %b expected 0001", rsp_valid); end
        eng_done = 1'b0;
        xfers = 0;
        last  = '0;
        for (int w = 0; w < 12; w++) begin
            #1;
            if ((req_valid & req_ready) != '0) begin xfers++; last = req_ready; end
            step();
        end
        vecs++; if (xfers !== 1) begin errs++; $display("FAIL full_one_more: got %0d expected 1", xfers); end
        vecs++; if (last !== 4'b0010) begin errs++; $display("FAIL full_next_grant: got %b expected 0010", last); end
        vecs++; if (q_count !== 3'd4) begin errs++; $display("FAIL full_refill: got %0d expected 4", q_count); end
        req_valid = '0;
    endtask

    task automatic test_stale_done();
        do_reset();
        load_addrs();
        eng_done  = 1'b1;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        vecs++; if ({eng_start, eng_a_addr} !== {1'b1, exp_a(0)}) begin errs++; $display("FAIL stale_issue: got %h expected %h", {eng_start, eng_a_addr}, {1'b1, exp_a(0)}); end
        step();
        vecs++; if (rsp_valid !== 4'b0000) begin errs++; $display("FAIL stale_wait1: got %b expected 0000", rsp_valid); end
        step();
        vecs++; if ({rsp_valid, eng_enable} !== 5'b0000_1) begin errs++; $display("FAIL stale_wait2: got %b expected 00001", {rsp_valid, eng_enable}); end
        step();
        vecs++; if (rsp_valid !== 4'b0001) begin errs++; $display("FAIL stale_rsp: got %b expected 0001", rsp_valid); end
        for (int c = 0; c < 3; c++) begin
            step();
            vecs++; if ({eng_start, rsp_valid, q_count} !== {1'b0, 4'b0000, 3'd1}) begin errs++; $display("FAIL stale_drain%0d: got %b expected 00000001", c, {eng_start, rsp_valid, q_count}); end
        end
        eng_done = 1'b0;
        step();
        vecs++; if (eng_start !== 1'b0) begin errs++; $display("FAIL stale_idle: got %b expected 0", eng_start); end
        step();
        vecs++; if ({eng_start, eng_a_addr} !== {1'b1, exp_a(1)}) begin errs++; $display("FAIL stale_next: got %h expected %h", {eng_start, eng_a_addr}, {1'b1, exp_a(1)}); end
    endtask

`ifdef VMMUL_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        load_addrs();
        req_valid = 4'b1000;
        step();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        vecs++; if ({eng_start, eng_a_addr} !== {1'b1, exp_a(3)}) begin errs++; $display("FAIL to_issue: got %h expected %h", {eng_start, eng_a_addr}, {1'b1, exp_a(3)}); end
        for (int c = 0; c < 8; c++) begin
            step();
            vecs++; if ({rsp_valid, eng_enable} !== 5'b0000_1) begin errs++; $display("FAIL to_wait%0d: got %b expected 00001", c, {rsp_valid, eng_enable}); end
        end
        step();
        vecs++; if ({rsp_valid, rsp_err, eng_enable} !== 6'b1000_1_0) begin errs++; $display("FAIL to_rsp: got %b expected 100010", {rsp_valid, rsp_err, eng_enable}); end
        repeat (3) step();
        vecs++; if ({eng_start, eng_a_addr} !== {1'b1, exp_a(0)}) begin errs++; $display("FAIL to_next: got %h expected %h", {eng_start, eng_a_addr}, {1'b1, exp_a(0)}); end
    endtask
`endif

    task automatic test_reset_mid();
        logic started;
        do_reset();
        load_addrs();
        req_valid = 4'b0111;
        repeat (3) step();
        req_valid = '0;
        step();
        vecs++; if ({eng_enable, q_count} !== {1'b1, 3'd2}) begin errs++; $display("FAIL rmid_pre: got %b expected 1010", {eng_enable, q_count}); end
        rst_n = 1'b0;
        #1;
        vecs++; if ({eng_start, eng_enable, busy, rsp_valid, q_count} !== 10'b0) begin errs++; $display("FAIL rmid_clear: got %b expected 0", {eng_start, eng_enable, busy, rsp_valid, q_count}); end
        vecs++; if (eng_a_addr !== 32'h0) begin errs++; $display("FAIL rmid_addr: got %h expected 0", eng_a_addr); end
        step();
        rst_n = 1'b1;
        started = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            started = started | eng_start | busy;
        end
        vecs++; if (started !== 1'b0) begin errs++; $display("FAIL rmid_quiet: got %b expected 0", started); end
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        vecs++; if ({eng_start, eng_a_addr} !== {1'b1, exp_a(3)}) begin errs++; $display("FAIL rmid_restart: got %h expected %h", {eng_start, eng_a_addr}, {1'b1, exp_a(3)}); end
    endtask

    initial begin
        req_a_addr = '0;
        req_b_addr = '0;
        req_r_addr = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_fifo();
        test_stale_done();
`ifdef VMMUL_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "bench timed out");
    end

endmodule
